// File: rtl/int8_simd_mac_unit.sv
// ---------------------------------------------------------------------------------------------
// int8_simd_mac_unit
//
// INT8 coprocessor execution unit on the custom-3 opcode (0x7B). Decodes MAC8, MAC8.ACC, MUL8,
// CLIP8, SIMD_DOT and SIMD_DOT_SAT, computes the result at issue, carries it through a
// fixed-latency pipeline and returns it through an in-order result FIFO.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop everything in flight and buffered (highest priority)
//   issue_*                issue handshake plus instruction word, ID and operand values
//   issue_accept_o         instruction legal, valid during the handshake cycle
//   issue_writeback_o      mirrors issue_accept_o
//   result_*               FIFO head (valid/ready), ID, rd index, data, overflow flag
//   busy_o                 pipeline or FIFO holds at least one entry
//
// Optional build macro INT8_SIMD_MAC_PERF_CNT_EN adds perf_issued_o (accepted instructions) and
// perf_stall_o (cycles with issue_valid_i && !issue_ready_o). Both wrap and clear on flush.
// ---------------------------------------------------------------------------------------------
module int8_simd_mac_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ID_W         = 4,
    parameter int unsigned PIPE_STAGES  = 2,
    parameter int unsigned RESULT_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [31:0]     issue_instr_i,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic [XLEN-1:0] issue_rs1_i,
    input  logic [XLEN-1:0] issue_rs2_i,
    input  logic [XLEN-1:0] issue_rd_i,
    output logic            issue_accept_o,
    output logic            issue_writeback_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [4:0]      result_rd_o,
    output logic [XLEN-1:0] result_data_o,
    output logic            result_ovf_o,
    output logic            busy_o
`ifdef INT8_SIMD_MAC_PERF_CNT_EN
    ,
    output logic [31:0]     perf_issued_o,
    output logic [31:0]     perf_stall_o
`endif
);

    localparam int unsigned NL    = XLEN / 8;
    localparam int unsigned CNT_W = $clog2(RESULT_DEPTH + 1);
    localparam int unsigned PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
    // Wide enough to hold rd plus every lane product exactly for any XLEN.
    localparam int unsigned ACC_W = XLEN + 18;

    localparam logic signed [XLEN-1:0] CLIP_MAX = XLEN'(127);
    localparam logic signed [XLEN-1:0] CLIP_MIN = XLEN'(-128);

    typedef enum logic [2:0] {
        OpMac8,
        OpMac8Acc,
        OpMul8,
        OpClip8,
        OpDot,
        OpDotSat
    } op_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            ovf;
    } entry_t;

    // ---------------------------------------------------------------- decode
    op_e  op;
    logic legal;

    always_comb begin
        op    = OpMac8;
        legal = 1'b0;
        if (issue_instr_i[6:0] == 7'b1111011 && issue_instr_i[14:12] == 3'b000) begin
            case (issue_instr_i[31:25])
                7'd0: begin op = OpMac8;    legal = 1'b1; end
                7'd1: begin op = OpMac8Acc; legal = 1'b1; end
                7'd2: begin op = OpMul8;    legal = 1'b1; end
                7'd3: begin op = OpClip8;   legal = (issue_instr_i[24:20] == 5'd0); end
                7'd4: begin op = OpDot;     legal = 1'b1; end
                7'd5: begin op = OpDotSat;  legal = 1'b1; end
                default: ;
            endcase
        end
    end

    // rs1 register index is not needed by this unit.
    logic unused_rs1_field;
    assign unused_rs1_field = ^issue_instr_i[19:15];

    // ---------------------------------------------------------------- arithmetic
    logic signed [7:0]       a_s, b_s, r8_s;
    logic signed [15:0]      prod_s, lane_prod_s;
    logic signed [16:0]      mac8_s;
    logic signed [XLEN-1:0]  rs1_s, rd_s, prod_x_s, acc_s;
    logic signed [ACC_W-1:0] dot_s;
    logic                    dot_fits;
    logic [XLEN-1:0]         res_data;
    logic                    res_ovf;

    always_comb begin
        a_s      = $signed(issue_rs1_i[7:0]);
        b_s      = $signed(issue_rs2_i[7:0]);
        r8_s     = $signed(issue_rd_i[7:0]);
        rs1_s    = $signed(issue_rs1_i);
        rd_s     = $signed(issue_rd_i);
        prod_s   = 16'(a_s) * 16'(b_s);
        mac8_s   = 17'(prod_s) + 17'(r8_s);
        prod_x_s = XLEN'(prod_s);
        acc_s    = rd_s + prod_x_s;

        lane_prod_s = '0;
        dot_s       = ACC_W'(rd_s);
        for (int unsigned i = 0; i < NL; i++) begin
            lane_prod_s = 16'($signed(issue_rs1_i[8*i +: 8])) * 16'($signed(issue_rs2_i[8*i +: 8]));
            dot_s       = dot_s + ACC_W'(lane_prod_s);
        end
        // Exact sum fits in XLEN when all bits above the XLEN sign bit replicate it.
        dot_fits = (dot_s[ACC_W-1:XLEN-1] == {(ACC_W - XLEN + 1){dot_s[XLEN-1]}});

        res_data = '0;
        res_ovf  = 1'b0;
        case (op)
            OpMac8: begin
                res_data = {{(XLEN - 8){mac8_s[7]}}, mac8_s[7:0]};
                res_ovf  = (mac8_s[16:8] != {9{mac8_s[7]}});
            end
            OpMac8Acc: begin
                res_data = acc_s;
                res_ovf  = (rd_s[XLEN-1] == prod_x_s[XLEN-1]) && (acc_s[XLEN-1] != rd_s[XLEN-1]);
            end
            OpMul8: begin
                res_data = prod_x_s;
            end
            OpClip8: begin
                if (rs1_s > CLIP_MAX) begin
                    res_data = CLIP_MAX;
                    res_ovf  = 1'b1;
                end else if (rs1_s < CLIP_MIN) begin
                    res_data = CLIP_MIN;
                    res_ovf  = 1'b1;
                end else begin
                    res_data = rs1_s;
                end
            end
            OpDot: begin
                res_data = dot_s[XLEN-1:0];
                res_ovf  = !dot_fits;
            end
            OpDotSat: begin
                if (dot_fits) begin
                    res_data = dot_s[XLEN-1:0];
                end else begin
                    res_data = dot_s[ACC_W-1] ? {1'b1, {(XLEN - 1){1'b0}}}
                                              : {1'b0, {(XLEN - 1){1'b1}}};
                    res_ovf  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- issue handshake
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             issue_push;
    entry_t           issue_entry;

    assign issue_ready_o     = (occ_q < CNT_W'(RESULT_DEPTH)) && !flush_i;
    assign issue_push        = issue_valid_i && issue_ready_o && legal;
    assign issue_accept_o    = issue_push;
    assign issue_writeback_o = issue_push;

    always_comb begin
        issue_entry.id   = issue_id_i;
        issue_entry.rd   = issue_instr_i[11:7];
        issue_entry.data = res_data;
        issue_entry.ovf  = res_ovf;
    end

    // ---------------------------------------------------------------- pipeline
    // PIPE_STAGES-1 register stages: an entry accepted in cycle N reaches the FIFO write port
    // during cycle N+PIPE_STAGES-1.
    entry_t pipe_out;
    logic   pipe_out_valid;

    if (PIPE_STAGES <= 1) begin : g_no_pipe
        assign pipe_out       = issue_entry;
        assign pipe_out_valid = issue_push;
    end else begin : g_pipe
        entry_t                 stage_q [PIPE_STAGES-1];
        logic [PIPE_STAGES-2:0] vld_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                for (int unsigned k = 0; k < PIPE_STAGES - 1; k++) begin
                    stage_q[k] <= '0;
                end
            end else if (flush_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= issue_push;
                if (issue_push) begin
                    stage_q[0] <= issue_entry;
                end
                for (int unsigned k = 1; k < PIPE_STAGES - 1; k++) begin
                    vld_q[k]   <= vld_q[k-1];
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end

        assign pipe_out       = stage_q[PIPE_STAGES-2];
        assign pipe_out_valid = vld_q[PIPE_STAGES-2];
    end

    // ---------------------------------------------------------------- result FIFO
    entry_t           mem_q [RESULT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fifo_valid, fifo_push, fifo_pop;
    entry_t           head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy accounting guarantees a free slot whenever the pipeline delivers.
    assign fifo_valid = (cnt_q != '0);
    assign fifo_push  = pipe_out_valid && !flush_i;
    assign fifo_pop   = fifo_valid && result_ready_i && !flush_i;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        occ_d = occ_q;
        if (flush_i) begin
            cnt_d = '0;
            occ_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            occ_d = occ_q + CNT_W'(issue_push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            occ_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            occ_q <= occ_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= pipe_out;
        end
    end

    // Head fields are gated so the outputs read 0 whenever nothing valid is presented.
    assign result_valid_o = fifo_valid;
    assign result_id_o    = fifo_valid ? head.id   : '0;
    assign result_rd_o    = fifo_valid ? head.rd   : '0;
    assign result_data_o  = fifo_valid ? head.data : '0;
    assign result_ovf_o   = fifo_valid && head.ovf;
    assign busy_o         = (occ_q != '0);

`ifdef INT8_SIMD_MAC_PERF_CNT_EN
    // ---------------------------------------------------------------- perf counters
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else if (flush_i) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_q + 32'(issue_push);
            perf_stall_q  <= perf_stall_q + 32'(issue_valid_i && !issue_ready_o);
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_int8_simd_mac_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_int8_simd_mac_unit
//
// Directed self-checking bench for int8_simd_mac_unit with default parameters. Inputs change
// 1 ns after the rising edge; outputs are sampled 1 ns later, well away from the edge.
// ---------------------------------------------------------------------------------------------
module tb_int8_simd_mac_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ID_W = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [31:0]     issue_instr_i;
    logic [ID_W-1:0] issue_id_i;
    logic [XLEN-1:0] issue_rs1_i;
    logic [XLEN-1:0] issue_rs2_i;
    logic [XLEN-1:0] issue_rd_i;
    logic            issue_accept_o;
    logic            issue_writeback_o;
    logic            result_valid_o;
    logic            result_ready_i;
    logic [ID_W-1:0] result_id_o;
    logic [4:0]      result_rd_o;
    logic [XLEN-1:0] result_data_o;
    logic            result_ovf_o;
    logic            busy_o;
`ifdef INT8_SIMD_MAC_PERF_CNT_EN
    logic [31:0]     perf_issued_o;
    logic [31:0]     perf_stall_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    int8_simd_mac_unit dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_rd_i        (issue_rd_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_rd_o       (result_rd_o),
        .result_data_o     (result_data_o),
        .result_ovf_o      (result_ovf_o),
        .busy_o            (busy_o)
`ifdef INT8_SIMD_MAC_PERF_CNT_EN
        ,
        .perf_issued_o     (perf_issued_o),
        .perf_stall_o      (perf_stall_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                        input logic [2:0] f3, input logic [4:0] rdf);
        return {f7, rs2f, 5'd1, f3, rdf, 7'b1111011};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [ID_W-1:0] id,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                           input logic [XLEN-1:0] rd);
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_id_i    = id;
        issue_rs1_i   = rs1;
        issue_rs2_i   = rs2;
        issue_rd_i    = rd;
    endtask

    // One instruction on an idle unit with result_ready_i high: result expected 2 cycles later.
    task automatic run_op(input string tag, input logic [6:0] f7, input logic [ID_W-1:0] id,
                          input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                          input logic [XLEN-1:0] rd, input logic [XLEN-1:0] exp_data,
                          input logic exp_ovf);
        logic [4:0] rdf;
        rdf = 5'(id) + 5'd3;
        present(enc(f7, 5'd0, 3'b000, rdf), id, rs1, rs2, rd);
        #1;
        check({tag, ".accept"}, 64'(issue_accept_o), 64'd1);
        check({tag, ".wb"}, 64'(issue_writeback_o), 64'd1);
        step();
        issue_valid_i = 1'b0;
        #1;
        check({tag, ".early"}, 64'(result_valid_o), 64'd0);
        step();
        check({tag, ".valid"}, 64'(result_valid_o), 64'd1);
        check({tag, ".data"}, 64'(result_data_o), 64'(exp_data));
        check({tag, ".ovf"}, 64'(result_ovf_o), 64'(exp_ovf));
        check({tag, ".id"}, 64'(result_id_o), 64'(id));
        check({tag, ".rd"}, 64'(result_rd_o), 64'(rdf));
        step();
        check({tag, ".idle"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        issue_valid_i  = 1'b0;
        issue_instr_i  = '0;
        issue_id_i     = '0;
        issue_rs1_i    = '0;
        issue_rs2_i    = '0;
        issue_rd_i     = '0;
        result_ready_i = 1'b1;

        // Reset state
        #2;
        check("rst.valid", 64'(result_valid_o), 64'd0);
        check("rst.busy", 64'(busy_o), 64'd0);
        check("rst.accept", 64'(issue_accept_o), 64'd0);
        check("rst.data", 64'(result_data_o), 64'd0);
        check("rst.id", 64'(result_id_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        check("rst.ready", 64'(issue_ready_o), 64'd1);
        step();

        // Arithmetic vectors
        run_op("dot", 7'd4, 4'd5, 32'h0102_0304, 32'hFFFF_FFFF, 32'd10, 32'h0000_0000, 1'b0);
        run_op("dotsat", 7'd5, 4'd6, 32'h8080_8080, 32'h8080_8080, 32'h7FFF_FF00,
               32'h7FFF_FFFF, 1'b1);
        run_op("dotwrap", 7'd4, 4'd7, 32'h8080_8080, 32'h8080_8080, 32'h7FFF_FF00,
               32'h8000_FF00, 1'b1);
        run_op("mac8", 7'd0, 4'd8, 32'h7F, 32'h02, 32'h01, 32'hFFFF_FFFF, 1'b1);
        run_op("clip.hi", 7'd3, 4'd9, 32'd400, 32'h0, 32'h0, 32'h0000_007F, 1'b1);
        run_op("clip.lo", 7'd3, 4'd10, 32'hFFFF_FF00, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b1);
        run_op("clip.in", 7'd3, 4'd11, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b0);
        run_op("acc.ovf", 7'd1, 4'd12, 32'h01, 32'h01, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("acc", 7'd1, 4'd13, 32'hFE, 32'h03, 32'd100, 32'h0000_005E, 1'b0);
        run_op("mul8", 7'd2, 4'd14, 32'h80, 32'h7F, 32'h0, 32'hFFFF_C080, 1'b0);

        // Backpressure: 5 back-to-back MUL8 (3*i) with the consumer stalled
        result_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            present(enc(7'd2, 5'd0, 3'b000, 5'd7), 4'(i), 32'd3, 32'(i), 32'd0);
            #1;
            check("bp.ready", 64'(issue_ready_o), 64'(i < 4));
            check("bp.accept", 64'(issue_accept_o), 64'(i < 4));
            step();
        end
        repeat (2) begin
            check("bp.full", 64'(issue_ready_o), 64'd0);
            check("bp.head", 64'(result_id_o), 64'd0);
            step();
        end
        result_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp.drain.valid", 64'(result_valid_o), 64'd1);
            check("bp.drain.id", 64'(result_id_o), 64'(k));
            check("bp.drain.data", 64'(result_data_o), 64'(3 * k));
            if (k == 0) check("bp.id4.wait", 64'(issue_accept_o), 64'd0);
            if (k == 1) check("bp.id4.accept", 64'(issue_accept_o), 64'd1);
            step();
            if (k == 1) issue_valid_i = 1'b0;
        end
        #1;
        check("bp.empty", 64'(result_valid_o), 64'd0);
        check("bp.busy", 64'(busy_o), 64'd0);
        step();

        // Illegal encodings
        present(enc(7'd2, 5'd0, 3'b001, 5'd4), 4'd1, 32'd5, 32'd5, 32'd0);
        #1;
        check("ill.f3.accept", 64'(issue_accept_o), 64'd0);
        check("ill.f3.wb", 64'(issue_writeback_o), 64'd0);
        check("ill.f3.ready", 64'(issue_ready_o), 64'd1);
        step();
        present(enc(7'd3, 5'd5, 3'b000, 5'd4), 4'd2, 32'd5, 32'd0, 32'd0);
        #1;
        check("ill.clip.accept", 64'(issue_accept_o), 64'd0);
        step();
        present(enc(7'd6, 5'd0, 3'b000, 5'd4), 4'd3, 32'd5, 32'd5, 32'd0);
        #1;
        check("ill.f7.accept", 64'(issue_accept_o), 64'd0);
        step();
        issue_valid_i = 1'b0;
        repeat (3) step();
        check("ill.noresult", 64'(result_valid_o), 64'd0);
        check("ill.busy", 64'(busy_o), 64'd0);

        // Flush with two buffered, one in the pipeline and one presented
        result_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(enc(7'd2, 5'd0, 3'b000, 5'd2), 4'(8 + i), 32'd2, 32'(i + 1), 32'd0);
            step();
        end
        present(enc(7'd2, 5'd0, 3'b000, 5'd2), 4'd11, 32'd2, 32'd9, 32'd0);
        flush_i = 1'b1;
        #1;
        check("fl.ready", 64'(issue_ready_o), 64'd0);
        check("fl.accept", 64'(issue_accept_o), 64'd0);
        check("fl.busy.before", 64'(busy_o), 64'd1);
        check("fl.valid.before", 64'(result_valid_o), 64'd1);
        step();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        #1;
        check("fl.valid", 64'(result_valid_o), 64'd0);
        check("fl.busy", 64'(busy_o), 64'd0);
        check("fl.ready.after", 64'(issue_ready_o), 64'd1);
        repeat (3) step();
        check("fl.stale", 64'(result_valid_o), 64'd0);
        result_ready_i = 1'b1;
        run_op("fl.post", 7'd2, 4'd15, 32'h05, 32'h07, 32'h0, 32'h0000_0023, 1'b0);

        // Asynchronous reset with a buffered result
        result_ready_i = 1'b0;
        present(enc(7'd2, 5'd0, 3'b000, 5'd1), 4'd4, 32'd2, 32'd2, 32'd0);
        step();
        issue_valid_i = 1'b0;
        step();
        check("arst.pre", 64'(result_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.valid", 64'(result_valid_o), 64'd0);
        check("arst.busy", 64'(busy_o), 64'd0);
        step();
        rst_ni         = 1'b1;
        result_ready_i = 1'b1;
        step();
        run_op("arst.post", 7'd0, 4'd3, 32'hFF, 32'hFF, 32'h02, 32'h0000_0003, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
